// File: rtl/triplet_drainer.sv
// triplet_drainer
//   Drains (row, col, val) byte triplets from CHANNEL_NUM groups of three FIFO
//   lanes and presents them one at a time on a valid/ready output. A channel is
//   served only when all three of its lanes hold data. Channels are granted
//   round-robin, with channel 0 first after reset.
//   Each triplet takes the states ARB -> READ -> CAPTURE -> OUT, so at most
//   one triplet is presented every 4 cycles.
//
// Parameters
//   CHANNEL_NUM  number of channels (3 lanes each)
//   CH_W         channel index width, ceil(log2(CHANNEL_NUM))
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   fifo_dout   lane read data, lane l = 3*channel + field at bits [l*8+7:l*8]
//   fifo_empty  per-lane empty flags
//   fifo_rd     per-lane read enables (asserted only in READ)
//   m_valid     triplet valid
//   m_ready     downstream accept
//   m_channel   source channel of the presented triplet
//   m_row/m_col/m_val  triplet fields 0/1/2
//   busy        high whenever the FSM is not in ARB
//
// Configuration
//   DRAIN_SKIP_ZERO_EN  when defined, triplets whose val byte is 0x00 are
//                       consumed from the FIFOs but never presented.

module triplet_drainer #(
    parameter int CHANNEL_NUM = 4,
    parameter int CH_W        = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3*8*CHANNEL_NUM-1:0] fifo_dout,
    input  logic [3*CHANNEL_NUM-1:0]   fifo_empty,
    output logic [3*CHANNEL_NUM-1:0]   fifo_rd,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [CH_W-1:0]            m_channel,
    output logic [7:0]                 m_row,
    output logic [7:0]                 m_col,
    output logic [7:0]                 m_val,
    output logic                       busy
);

    typedef enum logic [1:0] {
        ARB,
        READ,
        CAPTURE,
        OUT
    } state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic [CH_W-1:0]   channel_q, channel_d;
    logic [7:0]        row_q, row_d;
    logic [7:0]        col_q, col_d;
    logic [7:0]        val_q, val_d;

    logic [CHANNEL_NUM-1:0]   eligible;
    logic [2*CHANNEL_NUM-1:0] rotated;
    logic                     found;
    logic [CH_W-1:0]          rr_pick;
    logic [23:0]              granted_bytes;

    always_comb begin
        eligible = '0;
        for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            eligible[c] = ~|fifo_empty[3*c +: 3];
        end
    end

    // Rotating the doubled eligibility vector puts channel last_grant+1 at
    // bit 0, so the first set bit is the round-robin winner.
    always_comb begin
        rotated = {eligible, eligible} >> (32'(last_grant_q) + 32'd1);
        found   = 1'b0;
        rr_pick = last_grant_q;
        for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
            if (!found && rotated[i]) begin
                found   = 1'b1;
                rr_pick = CH_W'((32'(last_grant_q) + 32'd1 + i) % CHANNEL_NUM);
            end
        end
    end

    // last_grant_q doubles as the current grant from READ through OUT.
    always_comb begin
        granted_bytes = '0;
        fifo_rd       = '0;
        for (int unsigned c = 0; c < CHANNEL_NUM; c++) begin
            if (CH_W'(c) == last_grant_q) begin
                granted_bytes   = fifo_dout[24*c +: 24];
                fifo_rd[3*c +: 3] = {3{state_q == READ}};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        channel_d    = channel_q;
        row_d        = row_q;
        col_d        = col_q;
        val_d        = val_q;
        unique case (state_q)
            ARB: begin
                if (found) begin
                    last_grant_d = rr_pick;
                    state_d      = READ;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
`ifdef DRAIN_SKIP_ZERO_EN
                if (granted_bytes[23:16] == 8'h00) begin
                    state_d = ARB;
                end else begin
                    row_d     = granted_bytes[7:0];
                    col_d     = granted_bytes[15:8];
                    val_d     = granted_bytes[23:16];
                    channel_d = last_grant_q;
                    state_d   = OUT;
                end
`else
                row_d     = granted_bytes[7:0];
                col_d     = granted_bytes[15:8];
                val_d     = granted_bytes[23:16];
                channel_d = last_grant_q;
                state_d   = OUT;
`endif
            end
            OUT: begin
                if (m_ready) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB;
            last_grant_q <= CH_W'(CHANNEL_NUM - 1);
            channel_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            val_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            channel_q    <= channel_d;
            row_q        <= row_d;
            col_q        <= col_d;
            val_q        <= val_d;
        end
    end

    assign m_valid   = (state_q == OUT);
    assign busy      = (state_q != ARB);
    assign m_channel = channel_q;
    assign m_row     = row_q;
    assign m_col     = col_q;
    assign m_val     = val_q;

endmodule

// File: tb/tb_triplet_drainer.sv
// Directed bench for triplet_drainer with behavioural FIFO lanes (1-cycle read
// latency) and a scoreboard of expected triplets checked at each handshake.

module tb_triplet_drainer;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int L  = 3 * N;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*L-1:0]  fifo_dout;
    logic [L-1:0]    fifo_empty;
    logic [L-1:0]    fifo_rd;
    logic            m_valid;
    logic            m_ready;
    logic [CW-1:0]   m_channel;
    logic [7:0]      m_row, m_col, m_val;
    logic            busy;

    always #5 clk = ~clk;

    triplet_drainer #(.CHANNEL_NUM(N), .CH_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_channel  (m_channel),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_val      (m_val),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO lane model
    logic [7:0]  mem [L][16];
    int unsigned wptr [L];
    int unsigned rptr [L];

    always_comb begin
        for (int l = 0; l < L; l++) fifo_empty[l] = (wptr[l] == rptr[l]);
    end

    always @(posedge clk) begin
        for (int l = 0; l < L; l++) begin
            if (fifo_rd[l] === 1'b1) begin
                check("rd_nonempty", 64'(wptr[l] != rptr[l]), 64'd1);
                fifo_dout[l*8 +: 8] <= mem[l][rptr[l] % 16];
                rptr[l] <= rptr[l] + 1;
            end
        end
    end

    // Scoreboard
    logic [25:0] sb [$];
    logic [25:0] exp_t;
    int          hs_cyc [$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t = sb.pop_front();
                check("triplet", 64'({m_channel, m_row, m_col, m_val}), 64'(exp_t));
            end
            hs_cyc.push_back(cyc);
        end
    end

    task automatic push_lane(input int lane, input logic [7:0] b);
        mem[lane][wptr[lane] % 16] = b;
        wptr[lane] = wptr[lane] + 1;
    endtask

    task automatic push_trip(input int ch, input logic [7:0] r, input logic [7:0] c, input logic [7:0] v);
        push_lane(3*ch, r);
        push_lane(3*ch + 1, c);
        push_lane(3*ch + 2, v);
    endtask

    task automatic expect_trip(input logic [1:0] ch, input logic [7:0] r, input logic [7:0] c, input logic [7:0] v);
        sb.push_back({ch, r, c, v});
    endtask

    task automatic wait_rd(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (fifo_rd != '0);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (m_valid === 1'b1);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && (busy === 1'b0) && (m_valid === 1'b0);
        end
        check(tag, 64'(ok), 64'd1);
    endtask

    initial begin
        int vcount;
        int n_hs;

        rst_n   = 1'b0;
        m_ready = 1'b0;
        for (int l = 0; l < L; l++) wptr[l] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_rd", 64'(fifo_rd), 64'h0);
        check("rst_valid",   64'(m_valid), 64'h0);
        check("rst_data",    64'({m_channel, m_row, m_col, m_val}), 64'h0);
        check("rst_busy",    64'(busy), 64'h0);

        // Single channel 1 triplet, read then presented 2 cycles later
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        push_trip(1, 8'h05, 8'h07, 8'h2A);
        expect_trip(2'd1, 8'h05, 8'h07, 8'h2A);
        wait_rd("t1_rd_seen");
        check("t1_rd", 64'(fifo_rd), 64'h038);
        @(negedge clk);
        check("t1_capture", 64'({fifo_rd, m_valid}), 64'h0);
        @(negedge clk);
        check("t1_valid", 64'(m_valid), 64'd1);
        check("t1_busy",  64'(busy), 64'd1);
        wait_idle("t1_idle");

        // Back-pressure: outputs hold for 10 cycles, then release
        @(posedge clk); #1;
        m_ready = 1'b0;
        push_trip(3, 8'h11, 8'h22, 8'h33);
        expect_trip(2'd3, 8'h11, 8'h22, 8'h33);
        wait_valid("t2_valid_seen");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_hold", 64'({m_valid, fifo_rd, m_channel, m_row, m_col, m_val}),
                  64'({1'b1, 12'h000, 2'd3, 8'h11, 8'h22, 8'h33}));
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_arb", 64'({m_valid, busy}), 64'h0);

        // Partially filled channel is not eligible
        @(posedge clk); #1;
        push_lane(6, 8'h44);
        push_lane(7, 8'h55);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_idle", 64'({fifo_rd, m_valid}), 64'h0);
        end
        @(posedge clk); #1;
        push_lane(8, 8'h66);
        expect_trip(2'd2, 8'h44, 8'h55, 8'h66);
        wait_rd("t3_rd_seen");
        check("t3_rd", 64'(fifo_rd), 64'h1C0);
        wait_idle("t3_idle_end");

        // All channels loaded across reset: order 0,1,2,3,0 at 4-cycle spacing
        @(posedge clk); #1;
        rst_n = 1'b0;
        hs_cyc.delete();
        push_trip(0, 8'hA1, 8'hA2, 8'hA3);
        push_trip(1, 8'hB1, 8'hB2, 8'hB3);
        push_trip(2, 8'hC1, 8'hC2, 8'hC3);
        push_trip(3, 8'hD1, 8'hD2, 8'hD3);
        push_trip(0, 8'hE1, 8'hE2, 8'hE3);
        expect_trip(2'd0, 8'hA1, 8'hA2, 8'hA3);
        expect_trip(2'd1, 8'hB1, 8'hB2, 8'hB3);
        expect_trip(2'd2, 8'hC1, 8'hC2, 8'hC3);
        expect_trip(2'd3, 8'hD1, 8'hD2, 8'hD3);
        expect_trip(2'd0, 8'hE1, 8'hE2, 8'hE3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100 && hs_cyc.size() < 5; i++) @(negedge clk);
        n_hs = hs_cyc.size();
        check("t4_count", 64'(n_hs), 64'd5);
        if (n_hs == 5) begin
            for (int i = 1; i < 5; i++) check("t4_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd4);
        end
        wait_idle("t4_idle");

        // Reset during CAPTURE drops the triplet and restores channel 0 priority
        @(posedge clk); #1;
        push_trip(1, 8'h77, 8'h88, 8'h99);
        wait_rd("t5_rd_seen");
        check("t5_rd", 64'(fifo_rd), 64'h038);
        @(negedge clk);
        check("t5_cap_busy", 64'({busy, m_valid}), 64'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst", 64'({m_valid, fifo_rd, busy}), 64'h0);
        push_trip(3, 8'h31, 8'h32, 8'h33);
        push_trip(0, 8'h01, 8'h02, 8'h03);
        expect_trip(2'd0, 8'h01, 8'h02, 8'h03);
        expect_trip(2'd3, 8'h31, 8'h32, 8'h33);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_rd("t5_rd2_seen");
        check("t5_first", 64'(fifo_rd), 64'h007);
        wait_idle("t5_idle");

        // Zero val byte on channel 0
        @(posedge clk); #1;
        push_trip(0, 8'hA0, 8'hB0, 8'h00);
`ifdef DRAIN_SKIP_ZERO_EN
        wait_rd("t6_rd_seen");
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_valid === 1'b1) vcount++;
        end
        check("t6_skip_valid", 64'(vcount), 64'd0);
        check("t6_skip_busy",  64'(busy), 64'd0);
`else
        vcount = 0;
        expect_trip(2'd0, 8'hA0, 8'hB0, 8'h00);
        wait_rd("t6_rd_seen");
        check("t6_rd", 64'(fifo_rd) + 64'(vcount), 64'h007);
        wait_idle("t6_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/triplet_drainer.md
TRIPLET_DRAINER -- requirements
Module: triplet_drainer

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, giving the number of channels; each channel owns 3 FIFO lanes.
REQ-002 SHALL have parameter CH_W, default 2, giving the channel-index width; CH_W = ceil(log2(CHANNEL_NUM)).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port fifo_dout  input  3*8*CHANNEL_NUM  FIFO read data; lane i occupies bits [i*8+7:i*8].
REQ-007 SHALL have port fifo_empty  input  3*CHANNEL_NUM  per-lane FIFO empty flags.
REQ-008 SHALL have port fifo_rd  output  3*CHANNEL_NUM  per-lane FIFO read enables.
REQ-009 SHALL have port m_valid  output  1  output triplet valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_channel  output  CH_W  source channel of the presented triplet.
REQ-012 SHALL have ports m_row, m_col and m_val, each an 8-bit output carrying field 0, 1 and 2 of the triplet.
REQ-013 SHALL have port busy  output  1  high whenever the state is not ARB.

Function
REQ-014 Lane mapping SHALL be lane = 3*c + f, where c is the channel and f is the field (0=row, 1=col, 2=val).
REQ-015 A channel SHALL be eligible only when all 3 of its fifo_empty bits are 0.
REQ-016 SHALL run FSM states ARB -> READ -> CAPTURE -> OUT -> ARB.
REQ-017 ARB: if any channel is eligible, grant round-robin starting at (last_grant+1) mod CHANNEL_NUM, register the grant and go to READ; otherwise stay in ARB.
REQ-018 READ: fifo_rd SHALL be 1 on exactly the 3 lanes of the granted channel for exactly one cycle; all other fifo_rd bits SHALL be 0.
REQ-019 CAPTURE: the FIFO read latency is 1 cycle; the 3 granted fifo_dout bytes SHALL be latched into the output registers and m_channel set to the grant.
REQ-020 OUT: m_valid SHALL be 1; on m_valid && m_ready the FSM SHALL go to ARB with m_valid 0 on the next cycle.
REQ-021 m_row, m_col, m_val and m_channel SHALL hold stable while m_valid is 1 and m_ready is 0.
REQ-022 fifo_rd SHALL never be asserted outside READ, so an empty FIFO is never read.
REQ-023 An m_ready pulse while m_valid is 0 SHALL be ignored.
REQ-024 Peak throughput SHALL be one triplet per 4 cycles with m_ready held at 1.
REQ-025 Round-robin pointer: last_grant SHALL wrap from CHANNEL_NUM-1 to 0.
REQ-026 A channel that deasserts eligibility between ARB and READ is impossible by construction, since only this block reads the FIFOs; no recovery logic is required.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously enter ARB with fifo_rd=0, m_valid=0, m_row/m_col/m_val=0, m_channel=0, last_grant=CHANNEL_NUM-1 (so channel 0 is first priority) and busy=0.
REQ-028 Reset mid-operation SHALL drop any captured or pending triplet; the FIFOs are not restored.
REQ-029 Leaving reset SHALL be synchronous to clk; the first grant occurs no earlier than the first rising edge with rst_n high.

Configuration
REQ-030 Macro DRAIN_SKIP_ZERO_EN, when defined: in CAPTURE, if the val byte is 0x00, the triplet SHALL be discarded (consumed, never presented), and the FSM SHALL go directly to ARB with m_valid staying 0.
REQ-031 Macro DRAIN_SKIP_ZERO_EN, when undefined: zero-valued triplets SHALL be presented like any other.

Verification
REQ-032 Channel 1 has row/col/val = 0x05/0x07/0x2A and all others are empty; m_ready=1 -> fifo_rd = 0x038 for 1 cycle, then m_valid with m_channel=1 and 0x05/0x07/0x2A 2 cycles later.
REQ-033 All 4 channels non-empty and m_ready=1 after reset -> grant order 0,1,2,3,0, with 4 cycles between m_valid pulses.
REQ-034 Channel 2 has only lanes 6 and 7 non-empty -> no fifo_rd, m_valid stays 0; filling lane 8 -> channel 2 is served.
REQ-035 m_ready held 0 for 10 cycles in OUT -> outputs stable, fifo_rd stays 0; m_ready=1 -> FSM returns to ARB next cycle.
REQ-036 Assert rst_n low during CAPTURE -> m_valid=0 and fifo_rd=0 immediately; after release, channel 0 has first priority.
REQ-037 Channel 0 triplet with val=0x00 -> presented with DRAIN_SKIP_ZERO_EN undefined; with it defined, it is consumed with no m_valid.
